// File: rtl/mpy_seq_ctrl.sv
// mpy_seq_ctrl: operand FIFO + sequencer + result collector for the serial 8x8 signed multiplier.
// Ports: CLK, reset (sync, active-high); in_valid/in_ready/in_a/in_b operand push;
//   mpy_start/mpy_a/mpy_b/mpy_out/mpy_valid multiplier side;
//   res_valid/res_ready/res_prod/res_err result port; busy.
// Option: define MPY_SEQ_CHECK_EN to compare the multiplier product against a shadow product.
module mpy_seq_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mpy_start,
  output logic [7:0]  mpy_a,
  output logic [7:0]  mpy_b,
  input  logic [15:0] mpy_out,
  input  logic        mpy_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_prod,
  output logic        res_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmr;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic hit_to;
  logic capture;
  logic abort;

  // ---------------- FIFO ----------------
  assign fifo_nonempty = (count != '0);
  assign in_ready      = (count < CW'(DEPTH)) && !reset;
  assign push          = in_valid && in_ready;
  // Pop only from IDLE; a push into an empty FIFO is visible next cycle.
  assign pop           = (state == IDLE) && fifo_nonempty;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- FSM ----------------
  // tmr counts completed WAIT cycles; this WAIT cycle is the TIMEOUT-th one.
  assign hit_to  = (tmr == TW'(TIMEOUT - 1));
  assign capture = (state == WAIT) && mpy_valid;
  assign abort   = (state == WAIT) && !mpy_valid && hit_to;

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (fifo_nonempty) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (capture || abort) state_nxt = HOLD;
      HOLD:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mpy_start = (state == START);
    res_valid = (state == HOLD);
    busy      = (state != IDLE) || fifo_nonempty;
  end

  // ---------------- datapath ----------------
`ifdef MPY_SEQ_CHECK_EN
  logic signed [15:0] head_a;
  logic signed [15:0] head_b;
  logic        [15:0] head_prod;
  logic        [15:0] shadow;

  assign head_a    = 16'($signed(mem_a[rd_ptr]));
  assign head_b    = 16'($signed(mem_b[rd_ptr]));
  assign head_prod = 16'(head_a * head_b);

  always_ff @(posedge CLK) begin
    if (reset)    shadow <= '0;
    else if (pop) shadow <= head_prod;
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      mpy_a    <= '0;
      mpy_b    <= '0;
      tmr      <= '0;
      res_prod <= '0;
      res_err  <= 1'b0;
    end else begin
      if (pop) begin
        mpy_a <= mem_a[rd_ptr];
        mpy_b <= mem_b[rd_ptr];
        tmr   <= '0;
      end else if (state == WAIT) begin
        tmr <= tmr + 1'b1;
      end
      // Valid wins over a coinciding timeout.
      if (capture) begin
        res_prod <= mpy_out;
`ifdef MPY_SEQ_CHECK_EN
        res_err  <= (mpy_out != shadow);
`else
        res_err  <= 1'b0;
`endif
      end else if (abort) begin
        res_prod <= '0;
        res_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpy_seq_ctrl.sv
// tb_mpy_seq_ctrl: scoreboard bench for mpy_seq_ctrl with a behavioural serial multiplier.
// Multiplier modes per job: 0 normal, 1 never valid, 2 product off by one.
module tb_mpy_seq_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
`ifdef MPY_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        mpy_start;
  logic [7:0]  mpy_a;
  logic [7:0]  mpy_b;
  logic [15:0] mpy_out = '0;
  logic        mpy_valid = 1'b0;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_prod;
  logic        res_err;
  logic        busy;

  logic rr_fix = 1'b0;
  logic rr_rand = 1'b0;
  bit   rand_rr = 1'b0;
  assign res_ready = rand_rr ? rr_rand : rr_fix;

  always #5 CLK = ~CLK;

  mpy_seq_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mpy_start(mpy_start), .mpy_a(mpy_a), .mpy_b(mpy_b),
    .mpy_out(mpy_out), .mpy_valid(mpy_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_prod(res_prod), .res_err(res_err), .busy(busy)
  );

  typedef struct {
    logic [15:0] prod;
    logic        err;
    bit          dead;
  } exp_t;

  exp_t exp_q[$];
  int   mode_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 16'(ia * ib);
  endfunction

  always @(posedge CLK) cyc++;

  // Behavioural multiplier: restart on mpy_start, product after a random latency.
  int          m_cnt = 0;
  int          m_mode = 0;
  logic [15:0] m_prod = '0;
  always @(posedge CLK) begin
    if (reset) begin
      m_cnt = 0;
      mpy_valid <= 1'b0;
    end else if (mpy_start) begin
      m_mode = (mode_q.size() != 0) ? mode_q.pop_front() : 0;
      m_prod = ref_mul(mpy_a, mpy_b) + ((m_mode == 2) ? 16'd1 : 16'd0);
      m_cnt = int'($urandom_range(1, 12));
      mpy_valid <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_mode != 1) begin
        mpy_valid <= 1'b1;
        mpy_out   <= m_prod;
      end
    end
  end

  // Monitor: pops the scoreboard on each result handshake.
  int          starts = 0;
  int          start_cyc = 0;
  int          hold_cyc = 0;
  bit          prev_hs = 0;
  bit          prev_v = 0;
  bit          hold_seen = 0;
  logic [16:0] held = '0;
  exp_t        e;

  always @(negedge CLK) begin
    if (reset) begin
      starts = 0;
      prev_hs = 0;
      prev_v = 0;
      hold_seen = 0;
    end else begin
      if (mpy_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (prev_hs) chk("single_cycle_valid", 32'(res_valid), 32'd0);
      prev_hs = 0;
      if (res_valid && !prev_v) hold_cyc = cyc;
      if (res_valid) begin
        if (hold_seen) chk("hold_stable", 32'({res_err, res_prod}), 32'(held));
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_result: got prod %0d err %0d, none expected",
                     res_prod, res_err);
          end else begin
            e = exp_q.pop_front();
            chk("res_prod", 32'(res_prod), 32'(e.prod));
            chk("res_err", 32'(res_err), 32'(e.err));
            if (e.dead)
              chk("timeout_latency",
                  32'((hold_cyc - start_cyc >= TIMEOUT) &&
                      (hold_cyc - start_cyc <= TIMEOUT + 2)), 32'd1);
          end
          chk("starts_per_job", 32'(starts), 32'd1);
          starts = 0;
          prev_hs = 1;
          hold_seen = 0;
        end else begin
          hold_seen = 1;
          held = {res_err, res_prod};
        end
      end else begin
        hold_seen = 0;
      end
      prev_v = res_valid;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input int mode,
                      input int budget, output bit acc);
    exp_t x;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    acc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        acc = 1;
        x.dead = (mode == 1);
        x.prod = (mode == 1) ? 16'd0 : ref_mul(a, b) + ((mode == 2) ? 16'd1 : 16'd0);
        x.err  = (mode == 1) ? 1'b1 : ((mode == 2) && CHK);
        exp_q.push_back(x);
        mode_q.push_back(mode);
        @(posedge CLK);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_ok(input logic [7:0] a, input logic [7:0] b, input int mode);
    bit acc;
    push(a, b, mode, 500, acc);
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !busy && !res_valid) break;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_mpy_start", 32'(mpy_start), 32'd0);
    chk("rst_mpy_a", 32'(mpy_a), 32'd0);
    chk("rst_mpy_b", 32'(mpy_b), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_prod", 32'(res_prod), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit acc;
    int nacc;
    int md;

    repeat (3) begin
      @(negedge CLK);
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    end
    @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check_reset_vals();
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;

    // Basic product
    rr_fix = 1'b1;
    push_ok(8'd73, 8'd91, 0);
    drain(200);

    // Zero and sign operands, back-to-back
    push_ok(8'd0, 8'd43, 0);
    push_ok(8'd10, 8'd14, 0);
    push_ok(8'h80, 8'h80, 0);
    push_ok(8'd100, 8'd60, 0);
    drain(400);

    // Backpressure: DEPTH queued plus one in flight
    rr_fix = 1'b0;
    nacc = 0;
    for (int i = 1; i <= 6; i++) begin
      push(8'(i), 8'(i), 0, (i == 6) ? 30 : 60, acc);
      nacc += int'(acc);
    end
    chk("accepted_when_full", 32'(nacc), 32'(DEPTH + 1));
    @(negedge CLK);
    chk("in_ready_full", 32'(in_ready), 32'd0);
    @(posedge CLK);
    #1 rr_fix = 1'b1;
    drain(600);
    @(negedge CLK);
    chk("in_ready_recovered", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;

    // Timeout followed by a normal job
    push_ok(8'd12, 8'd79, 1);
    push_ok(8'd5, 8'hF9, 0);
    drain(400);

    // Reset mid-operation with two pairs queued
    push_ok(8'd20, 8'd3, 1);
    push_ok(8'd4, 8'd4, 0);
    push_ok(8'd9, 8'd9, 0);
    repeat (4) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("busy_before_reset", 32'(busy), 32'd1);
    chk("no_result_yet", 32'(res_valid), 32'd0);
    @(posedge CLK);
    #1 reset = 1'b1;
    @(negedge CLK);
    chk("in_ready_mid_reset", 32'(in_ready), 32'd0);
    @(posedge CLK);
    #1 reset = 1'b0;
    exp_q.delete();
    mode_q.delete();
    @(negedge CLK);
    check_reset_vals();
    repeat (60) @(negedge CLK);
    chk("idle_after_reset", 32'(busy), 32'd0);
    @(posedge CLK);
    #1;
    push_ok(8'd12, 8'd79, 0);
    drain(200);

    // Faulty multiplier: flagged only when checking is built in
    push_ok(8'd73, 8'd91, 2);
    drain(200);

    // Randomized jobs with random result backpressure
    rand_rr = 1'b1;
    for (int i = 0; i < 30; i++) begin
      md = int'($urandom_range(0, 9));
      md = (md == 0) ? 1 : ((md == 1) ? 2 : 0);
      push_ok(8'($urandom), 8'($urandom), md);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end
    drain(8000);
    rand_rr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  always @(posedge CLK) begin
    #1 rr_rand = 1'($urandom_range(0, 1));
  end

endmodule
